sfp_mul_sched: RTL and testbench

- Time-shares one pipelined signed fixed-point multiplier among N requesters, e.g. the ray/vector units of the raytracer.
- Operands and results use the team's signed fixed-point format: IW integer bits (sign included), QW fractional bits, WL = IW+QW total bits.
- A round-robin arbiter issues at most one operation per cycle into a LAT-deep pipeline. Each result returns on a shared tagged result channel with valid/ready backpressure.

---
 rtl/sfp_mul_sched.sv | 219 +++++++++++++++++++++
 tb/tb_sfp_mul_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_mul_sched.sv
// sfp_mul_sched: round-robin scheduler sharing one pipelined signed
// fixed-point multiplier among N requesters. Results return in issue
// order on a single tagged valid/ready channel. Rounding is
// round-half-up and saturation is applied in the final stage.
module sfp_mul_sched #(
  parameter  int N   = 4,
  parameter  int IW  = 8,
  parameter  int QW  = 8,
  parameter  int LAT = 2,
  localparam int IDW = $clog2(N),
  localparam int WL  = IW + QW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*WL-1:0] req_a,
  input  logic [N*WL-1:0] req_b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [IDW-1:0]  res_id,
  output logic [WL-1:0]   res_val,
  output logic            res_sat
);

  localparam int PW = 2 * WL;
  // One extra bit so the rounding add can never overflow.
  localparam int EW = 2 * WL + 1;

  localparam logic signed [EW-1:0] RND =
    (QW > 0) ? (EW'(1) << ((QW > 0) ? QW - 1 : 0)) : '0;
  localparam logic signed [EW-1:0] SAT_MIN = -(EW'(1) << (WL - 1));
  localparam logic signed [EW-1:0] SAT_MAX = ~SAT_MIN;

  logic [IDW-1:0]       ptr_q, ptr_d;
  logic                 stall;
  logic                 accept;
  logic                 found;
  logic [IDW-1:0]       winner;
  int                   arbIdx;
  logic signed [WL-1:0] aSel, bSel;
  logic signed [PW-1:0] prod;

  // Inputs to the final (round/saturate) stage.
  logic                 outInVld;
  logic [IDW-1:0]       outInId;
  logic signed [PW-1:0] outInProd;

  logic                 outVld_q, outVld_d;
  logic [IDW-1:0]       outId_q, outId_d;
  logic [WL-1:0]        outVal_q, outVal_d;
  logic                 outSat_q, outSat_d;
  logic [WL:0]          roundRes;

  // Round half-up, arithmetic shift by QW, clamp to WL bits; returns {sat, value}.
  function automatic logic [WL:0] roundSat(input logic signed [PW-1:0] p);
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] shifted;
    logic [WL:0]          r;
    ext     = {p[PW-1], p};
    ext     = ext + RND;
    shifted = ext >>> QW;
    if (shifted > SAT_MAX) begin
      r = {1'b1, SAT_MAX[WL-1:0]};
    end else if (shifted < SAT_MIN) begin
      r = {1'b1, SAT_MIN[WL-1:0]};
    end else begin
      r = {1'b0, shifted[WL-1:0]};
    end
    return r;
  endfunction

  assign stall  = outVld_q && !res_ready;
  assign accept = found && !stall && !rst;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    arbIdx = 0;
    for (int k = 0; k < N; k++) begin
      arbIdx = int'(ptr_q) + k;
      if (arbIdx >= N) begin
        arbIdx = arbIdx - N;
      end
      if (!found && req_valid[arbIdx]) begin
        found  = 1'b1;
        winner = IDW'(arbIdx);
      end
    end
  end

  // Grant is one-hot on the winner, and only when the pipeline can take it.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign aSel = req_a[int'(winner)*WL +: WL];
  assign bSel = req_b[int'(winner)*WL +: WL];
  assign prod = PW'(aSel) * PW'(bSel);

  // Pointer moves past the winner only on an actual accept.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (int'(winner) == N - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = winner + IDW'(1);
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  generate
    if (LAT == 1) begin : gDirect
      assign outInVld  = accept;
      assign outInId   = winner;
      assign outInProd = prod;
    end else begin : gPipe
      localparam int PS = LAT - 1;
      logic [PS-1:0]        pVld_q, pVld_d;
      logic [IDW-1:0]       pId_q   [PS];
      logic [IDW-1:0]       pId_d   [PS];
      logic signed [PW-1:0] pProd_q [PS];
      logic signed [PW-1:0] pProd_d [PS];

      // Raw product stages shift forward unless the output is stalled.
      always_comb begin
        pVld_d  = pVld_q;
        pId_d   = pId_q;
        pProd_d = pProd_q;
        if (!stall) begin
          pVld_d[0]  = accept;
          pId_d[0]   = winner;
          pProd_d[0] = prod;
          for (int s = 1; s < PS; s++) begin
            pVld_d[s]  = pVld_q[s-1];
            pId_d[s]   = pId_q[s-1];
            pProd_d[s] = pProd_q[s-1];
          end
        end
      end

      // Product stage registers; reset discards anything in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          pVld_q <= '0;
          for (int s = 0; s < PS; s++) begin
            pId_q[s]   <= '0;
            pProd_q[s] <= '0;
          end
        end else begin
          pVld_q  <= pVld_d;
          pId_q   <= pId_d;
          pProd_q <= pProd_d;
        end
      end

      assign outInVld  = pVld_q[PS-1];
      assign outInId   = pId_q[PS-1];
      assign outInProd = pProd_q[PS-1];
    end
  endgenerate

  assign roundRes = roundSat(outInProd);

  // Final stage holds while stalled; bubbles load as all-zero outputs.
  always_comb begin
    outVld_d = outVld_q;
    outId_d  = outId_q;
    outVal_d = outVal_q;
    outSat_d = outSat_q;
    if (!stall) begin
      outVld_d = outInVld;
      if (outInVld) begin
        outId_d  = outInId;
        outVal_d = roundRes[WL-1:0];
        outSat_d = roundRes[WL];
      end else begin
        outId_d  = '0;
        outVal_d = '0;
        outSat_d = 1'b0;
      end
    end
  end

  // Output stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      outVld_q <= 1'b0;
      outId_q  <= '0;
      outVal_q <= '0;
      outSat_q <= 1'b0;
    end else begin
      outVld_q <= outVld_d;
      outId_q  <= outId_d;
      outVal_q <= outVal_d;
      outSat_q <= outSat_d;
    end
  end

  assign res_valid = outVld_q;
  assign res_id    = outId_q;
  assign res_val   = outVal_q;
  assign res_sat   = outSat_q;

endmodule

// File: tb/tb_sfp_mul_sched.sv
// tb_sfp_mul_sched: directed vectors with hand-computed results pushed
// into a scoreboard queue; a monitor pops and compares each result
// handshake on the output channel.
module tb_sfp_mul_sched;

  localparam int N   = 4;
  localparam int IW  = 8;
  localparam int QW  = 8;
  localparam int LAT = 2;
  localparam int WL  = IW + QW;
  localparam int IDW = $clog2(N);

  typedef struct {
    int          id;
    logic [15:0] val;
    logic        sat;
    int          due;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    reqValid;
  logic [N-1:0]    reqReady;
  logic [N*WL-1:0] reqA;
  logic [N*WL-1:0] reqB;
  logic            resValid;
  logic            resReady;
  logic [IDW-1:0]  resId;
  logic [WL-1:0]   resVal;
  logic            resSat;

  exp_t sbQ[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  sfp_mul_sched #(.N(N), .IW(IW), .QW(QW), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_a     (reqA),
    .req_b     (reqB),
    .res_valid (resValid),
    .res_ready (resReady),
    .res_id    (resId),
    .res_val   (resVal),
    .res_sat   (resSat)
  );

  // Free-running clock and edge counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a single requester for one cycle; check its grant and queue its result.
  task automatic applyStimulus(input int id, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] expVal, input logic expSat,
                               input bit track, input bit chkLat);
    exp_t e;
    reqValid = '0;
    reqValid[id] = 1'b1;
    reqA[id*WL +: WL] = a;
    reqB[id*WL +: WL] = b;
    @(negedge clk);
    checkOutput("grant_single", 32'(reqReady), 32'(1 << id));
    if (track) begin
      e.id  = id;
      e.val = expVal;
      e.sat = expSat;
      e.due = chkLat ? cyc + LAT : -1;
      sbQ.push_back(e);
    end
    @(posedge clk);
    #1;
    reqValid = '0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQ.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain_empty", 32'(sbQ.size()), 32'd0);
  endtask

  // Monitor: every accepted result is compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resValid === 1'b1 && resReady === 1'b1) begin
        if (sbQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_result: got id=%0d val=0x%0h expected no result", resId, resVal);
        end else begin
          e = sbQ.pop_front();
          checkOutput("res_id", 32'(resId), 32'(e.id));
          checkOutput("res_val", 32'(resVal), 32'(e.val));
          checkOutput("res_sat", 32'(resSat), 32'(e.sat));
          if (e.due >= 0) begin
            checkOutput("latency", 32'(cyc), 32'(e.due));
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    exp_t e;
    int   rot [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    rst      = 1'b1;
    resReady = 1'b1;
    reqValid = '1;
    reqA     = '0;
    reqB     = '0;

    // Reset state, and no grant while reset is high.
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(reqReady), 32'd0);
    checkOutput("reset_res_valid", 32'(resValid), 32'd0);
    checkOutput("reset_res_id", 32'(resId), 32'd0);
    checkOutput("reset_res_val", 32'(resVal), 32'd0);
    checkOutput("reset_res_sat", 32'(resSat), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    reqValid = '0;

    // Arithmetic vectors, back to back at full rate.
    applyStimulus(1, 16'h0180, 16'h0200, 16'h0300, 1'b0, 1'b1, 1'b1);
    applyStimulus(2, 16'h6400, 16'h0200, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    applyStimulus(3, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    applyStimulus(0, 16'h9C00, 16'h0200, 16'h8000, 1'b1, 1'b1, 1'b1);
    applyStimulus(1, 16'h0001, 16'h0080, 16'h0001, 1'b0, 1'b1, 1'b1);
    applyStimulus(2, 16'hFFFF, 16'h0080, 16'h0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(3, 16'hFE80, 16'h0200, 16'hFD00, 1'b0, 1'b1, 1'b1);
    applyStimulus(0, 16'h0100, 16'hFF00, 16'hFF00, 1'b0, 1'b1, 1'b1);
    waitDrain();

    // Rotation: pointer back to 0, all requesters valid for 8 cycles.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      reqA[i*WL +: WL] = 16'((i + 1) << 8);
      reqB[i*WL +: WL] = 16'h0200;
    end
    reqValid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("grant_rotation", 32'(reqReady), 32'(1 << rot[k]));
      e.id  = rot[k];
      e.val = 16'((rot[k] + 1) * 16'h0200);
      e.sat = 1'b0;
      e.due = cyc + LAT;
      sbQ.push_back(e);
      @(posedge clk);
      #1;
    end
    reqValid = '0;
    waitDrain();

    // Stall: hold results with res_ready low while requests are pending.
    applyStimulus(0, 16'h0100, 16'h0300, 16'h0300, 1'b0, 1'b1, 1'b0);
    applyStimulus(1, 16'h0200, 16'h0200, 16'h0400, 1'b0, 1'b1, 1'b0);
    resReady = 1'b0;
    reqValid = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_req_ready", 32'(reqReady), 32'd0);
      checkOutput("stall_res_valid", 32'(resValid), 32'd1);
      checkOutput("stall_res_id", 32'(resId), 32'd0);
      checkOutput("stall_res_val", 32'(resVal), 32'h0300);
      @(posedge clk);
      #1;
    end
    reqValid = '0;
    resReady = 1'b1;
    waitDrain();

    // Reset with two operations in flight; they must never appear.
    resReady = 1'b0;
    applyStimulus(2, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(3, 16'h0200, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0);
    rst      = 1'b1;
    reqValid = 4'b0100;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    reqValid = '0;
    @(negedge clk);
    checkOutput("midreset_res_valid", 32'(resValid), 32'd0);
    checkOutput("midreset_res_val", 32'(resVal), 32'd0);
    checkOutput("midreset_res_id", 32'(resId), 32'd0);
    @(posedge clk);
    #1;
    resReady = 1'b1;
    reqA[0*WL +: WL] = 16'h0300;
    reqB[0*WL +: WL] = 16'h0100;
    reqA[3*WL +: WL] = 16'h0500;
    reqB[3*WL +: WL] = 16'h0100;
    reqValid = 4'b1001;
    @(negedge clk);
    checkOutput("grant_after_reset", 32'(reqReady), 32'b0001);
    e.id  = 0;
    e.val = 16'h0300;
    e.sat = 1'b0;
    e.due = cyc + LAT;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    reqValid = '0;
    waitDrain();
    repeat (5) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
